// File: rtl/carry_select_adder.sv
// Carry-select adder computing A + B + Cin with registered sum, carry flag and
// signed-overflow flag. The lowest block ripples from Cin; each higher block
// precomputes both carry-in cases and the previous block's carry picks one.
module carry_select_adder #(
    parameter int DATA_WIDTH = 4,
    parameter int BLOCK_SIZE = 1
) (
    input  logic                  CLK,
    input  logic                  RST_n,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic                  Cin,
    output logic                  CF,
    output logic                  OF,
    output logic [DATA_WIDTH-1:0] S
);

    localparam int NUM_BLOCKS = (BLOCK_SIZE >= 1) ? (DATA_WIDTH / BLOCK_SIZE) : 1;

    // Reject block sizes that do not tile the operand width exactly.
    if (DATA_WIDTH < 1 || BLOCK_SIZE < 1 || (DATA_WIDTH % BLOCK_SIZE) != 0) begin : g_bad_params
        $error("carry_select_adder: BLOCK_SIZE must be >= 1 and divide DATA_WIDTH");
    end

    // Ripple-carry adder built from full adders. Returns
    // {carry out, carry into the block's top bit, block sum}.
    function automatic logic [BLOCK_SIZE+1:0] ripple_add(
        input logic [BLOCK_SIZE-1:0] a,
        input logic [BLOCK_SIZE-1:0] b,
        input logic                  c
    );
        logic [BLOCK_SIZE-1:0] sum_s;
        logic                  carry_s;
        logic                  msb_cin_s;
        sum_s     = {BLOCK_SIZE{1'b0}};
        carry_s   = c;
        msb_cin_s = c;
        for (int k = 0; k < BLOCK_SIZE; k++) begin
            msb_cin_s = carry_s;
            sum_s[k]  = a[k] ^ b[k] ^ carry_s;
            carry_s   = (a[k] & b[k]) | (carry_s & (a[k] ^ b[k]));
        end
        return {carry_s, msb_cin_s, sum_s};
    endfunction

    logic [DATA_WIDTH-1:0] sum_s;

    for (genvar i = 0; i < NUM_BLOCKS; i++) begin : g_blk
        logic [BLOCK_SIZE+1:0] res_s;  // selected {co, msb carry-in, sum}
        logic                  co_s;
        logic                  cm_s;

        if (i == 0) begin : g_base
            assign res_s = ripple_add(A[BLOCK_SIZE-1:0], B[BLOCK_SIZE-1:0], Cin);
        end else begin : g_sel
            logic [BLOCK_SIZE+1:0] res0_s;
            logic [BLOCK_SIZE+1:0] res1_s;
            assign res0_s = ripple_add(A[i*BLOCK_SIZE +: BLOCK_SIZE],
                                       B[i*BLOCK_SIZE +: BLOCK_SIZE], 1'b0);
            assign res1_s = ripple_add(A[i*BLOCK_SIZE +: BLOCK_SIZE],
                                       B[i*BLOCK_SIZE +: BLOCK_SIZE], 1'b1);
            assign res_s  = g_blk[i-1].co_s ? res1_s : res0_s;
        end

        assign co_s = res_s[BLOCK_SIZE+1];
        assign cm_s = res_s[BLOCK_SIZE];
        assign sum_s[i*BLOCK_SIZE +: BLOCK_SIZE] = res_s[BLOCK_SIZE-1:0];
    end

    logic                  carry_out_s;
    logic                  overflow_s;
    logic [DATA_WIDTH-1:0] s_r;
    logic                  cf_r;
    logic                  of_r;

    assign carry_out_s = g_blk[NUM_BLOCKS-1].co_s;
    assign overflow_s  = g_blk[NUM_BLOCKS-1].cm_s ^ carry_out_s;

    // Output registers: cleared asynchronously, load the adder result each edge.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            s_r  <= {DATA_WIDTH{1'b0}};
            cf_r <= 1'b0;
            of_r <= 1'b0;
        end else begin
            s_r  <= sum_s;
            cf_r <= carry_out_s;
            of_r <= overflow_s;
        end
    end

    assign S  = s_r;
    assign CF = cf_r;
    assign OF = of_r;

endmodule

// File: tb/tb_carry_select_adder.sv
// Scoreboard bench: three adder instances (block sizes 1, 2, 4) share the same
// operands; expected results are queued at issue and checked one edge later.
module tb_carry_select_adder;

    typedef struct {
        logic [3:0] s;
        logic       cf;
        logic       of;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] s1, s2, s4;
    logic       cf1, cf2, cf4;
    logic       of1, of2, of4;

    exp_t exp_q[$];
    int   checks;
    int   errors;

    carry_select_adder #(.DATA_WIDTH(4), .BLOCK_SIZE(1)) dut1 (
        .CLK(clk), .RST_n(rst_n), .A(a), .B(b), .Cin(cin), .CF(cf1), .OF(of1), .S(s1));
    carry_select_adder #(.DATA_WIDTH(4), .BLOCK_SIZE(2)) dut2 (
        .CLK(clk), .RST_n(rst_n), .A(a), .B(b), .Cin(cin), .CF(cf2), .OF(of2), .S(s2));
    carry_select_adder #(.DATA_WIDTH(4), .BLOCK_SIZE(4)) dut4 (
        .CLK(clk), .RST_n(rst_n), .A(a), .B(b), .Cin(cin), .CF(cf4), .OF(of4), .S(s4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [5:0] got, input logic [5:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got {S,CF,OF}=%b required %b", name, got, want);
        end
    endtask

    task automatic check_all(input string tag, input logic [5:0] want);
        check({tag, " bs1"}, {s1, cf1, of1}, want);
        check({tag, " bs2"}, {s2, cf2, of2}, want);
        check({tag, " bs4"}, {s4, cf4, of4}, want);
    endtask

    // Apply operands before the next rising edge and queue the expected result.
    task automatic drive(input logic [3:0] va, input logic [3:0] vb, input logic vc,
                         input logic [3:0] es, input logic ecf, input logic eof);
        exp_t e;
        @(negedge clk);
        a   = va;
        b   = vb;
        cin = vc;
        e.s  = es;
        e.cf = ecf;
        e.of = eof;
        exp_q.push_back(e);
    endtask

    // Monitor: after every rising edge, retire one queued expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_all("result", {e.s, e.cf, e.of});
        end
    end

    initial begin
        logic [4:0] full;
        logic       ov;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        a      = 4'b0000;
        b      = 4'b0000;
        cin    = 1'b0;

        #1;
        check_all("reset state", 6'b000000);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors with hand-computed results.
        drive(4'b0001, 4'b0100, 1'b0, 4'b0101, 1'b0, 1'b0);
        drive(4'b1101, 4'b1100, 1'b0, 4'b1001, 1'b1, 1'b0);
        drive(4'b0101, 4'b0111, 1'b0, 4'b1100, 1'b0, 1'b1);
        drive(4'b1000, 4'b1011, 1'b0, 4'b0011, 1'b1, 1'b1);
        drive(4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0);
        drive(4'b0111, 4'b0000, 1'b1, 4'b1000, 1'b0, 1'b1);
        drive(4'b1000, 4'b1111, 1'b1, 4'b1000, 1'b1, 1'b0);

        // Exhaustive sweep against plain integer addition.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    full = 5'(ia) + 5'(ib) + 5'(ic);
                    ov   = (ia[3] == ib[3]) && (full[3] != ia[3]);
                    drive(4'(ia), 4'(ib), 1'(ic), full[3:0], full[4], ov);
                end
            end
        end

        // Mid-stream asynchronous reset with nonzero outputs present.
        drive(4'b0101, 4'b0111, 1'b0, 4'b1100, 1'b0, 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all("async reset", 6'b000000);
        @(posedge clk);
        #1;
        check_all("reset hold", 6'b000000);
        a   = 4'b0001;
        b   = 4'b0100;
        cin = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
        check_all("release no edge", 6'b000000);
        begin
            exp_t e;
            e.s  = 4'b0101;
            e.cf = 1'b0;
            e.of = 1'b0;
            exp_q.push_back(e);
        end

        // Drain the scoreboard with a bounded wait.
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending results required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/carry_select_adder.md
Name: carry_select_adder

Overview:
Parameterised carry-select adder for A + B + Cin, with registered sum, carry flag and signed-overflow flag. The operand width is split into fixed-size blocks. The lowest block ripples directly from Cin. Every higher block precomputes results for carry-in 0 and 1, and the incoming block carry selects between them. Used as the adder/subtractor datapath primitive, with results consumed one clock after the operands are applied.

Parameters:
DATA_WIDTH  4  operand and sum width in bits; must be >= 1
BLOCK_SIZE  1  bits per carry-select block; must be >= 1 and divide DATA_WIDTH evenly (elaboration error otherwise)

Ports:
CLK    input   1           system clock; outputs update on the rising edge
RST_n  input   1           asynchronous active-low reset
A      input   DATA_WIDTH  operand A (unsigned or two's complement)
B      input   DATA_WIDTH  operand B
Cin    input   1           carry into bit 0
CF     output  1           registered carry out of the MSB
OF     output  1           registered two's-complement overflow flag
S      output  DATA_WIDTH  registered sum, A + B + Cin modulo 2^DATA_WIDTH

Behaviour:
- Reset: RST_n low forces S = 0, CF = 0, OF = 0 immediately, without waiting for CLK. These values are held while RST_n is low.
- Reset release: on the first rising CLK edge after RST_n goes high, the registers capture the current result.
- Latency and rate:
  - One cycle: operands present before rising edge k give their result on S/CF/OF after edge k.
  - Fully pipelined, one new operand set per cycle, no handshake.
- Combinational core, with NUM_BLOCKS = DATA_WIDTH / BLOCK_SIZE:
  - Block 0: BLOCK_SIZE-bit ripple-carry adder with carry-in Cin.
  - Block i (i >= 1): two BLOCK_SIZE-bit ripple-carry adders on the same operand slice, one with carry-in 0 and one with carry-in 1. A 2:1 mux driven by block i-1's selected carry-out picks that block's sum and carry-out.
  - Ripple adders are built from full adders: s = a ^ b ^ c; co = a&b | c&(a^b).
  - When BLOCK_SIZE == DATA_WIDTH the design degenerates to a single ripple adder, with no duplicate adders or muxes.
- Flags:
  - CF is the selected carry-out of the top block, i.e. bit DATA_WIDTH of A + B + Cin.
  - OF = (carry into the MSB) XOR (carry out of the MSB). The carry into the MSB is taken from the selected path of the top block.
  - OF is valid for signed interpretation. CF is valid for unsigned interpretation. Both are always computed.
- Subtraction: not performed internally. The caller supplies ~B and Cin = 1.
- Boundaries:
  - All-ones + 0 with Cin = 1 wraps S to 0 with CF = 1.
  - With DATA_WIDTH = 1, the MSB carry-in is Cin.
- Input changes between clock edges have no effect on the outputs until the next rising edge.

Test Plan:
- DATA_WIDTH=4, BLOCK_SIZE=1, Cin=0, A=0001, B=0100 -> after next edge S=0101, CF=0, OF=0.
- A=1101, B=1100, Cin=0 -> S=1001, CF=1, OF=0 (-3 + -4 = -7, no signed overflow).
- A=0101, B=0111, Cin=0 -> S=1100, CF=0, OF=1 (5 + 7 overflows signed 4-bit).
- A=1000, B=1011, Cin=0 -> S=0011, CF=1, OF=1. Then A=1111, B=0000, Cin=1 -> S=0000, CF=1, OF=0.
- Repeat all vectors with BLOCK_SIZE=2 and BLOCK_SIZE=4 -> identical results. Exhaustive sweep of A, B, Cin compared against A + B + Cin, with S/CF/OF checked one cycle later.
- Assert RST_n low mid-stream, between clock edges, with nonzero outputs present -> S, CF, OF go to 0 immediately and stay 0 while RST_n is low. After release, the first rising edge loads the result of the current operands.
